// File: rtl/expr_result_misr.sv
// expr_result_misr
//   Capture stage for the generated expression blocks. Each accepted beat of
//   the packed result bus is folded into a WIDTH-bit MISR. A run of num_vecs_i
//   beats ends with a single pass/fail verdict that compares the signature
//   against a golden value latched at start.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset (release synchronised here)
//   start_i      1-cycle pulse, begins a run, samples num_vecs_i and golden_i
//   num_vecs_i   number of vectors in the run
//   golden_i     expected final signature
//   in_valid_i   in_data_i holds a result vector
//   in_data_i    packed result bus y[89:0]
//   in_ready_o   stage accepts a beat this cycle (RUN state only)
//   sig_o        current signature
//   vec_cnt_o    vectors accepted in the current run
//   busy_o       run in progress
//   done_o       run complete, verdict valid (held level)
//   pass_o       final signature matched golden (valid while done_o=1)
module expr_result_misr #(
  parameter int                 WIDTH = 90,
  parameter int                 CNT_W = 16,
  parameter logic [WIDTH-1:0]   POLY  = 90'h2D,
  parameter logic [WIDTH-1:0]   SEED  = 90'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vecs_i,
  input  logic [WIDTH-1:0] golden_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] sig_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One MISR step: shift left, fold the bit shifted out back through the taps,
  // then mix in the new vector.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    misr_step = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : {WIDTH{1'b0}}) ^ d;
  endfunction

  // Reset synchroniser: assertion passes straight through, release is
  // delayed by two clock edges so all flops leave reset on the same edge.
  logic rst_meta_q, rst_sync_q;

  // reset release synchroniser
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;

  logic             accept_s;
  logic             last_s;
  logic             launch_s;
  logic [WIDTH-1:0] sig_step_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign accept_s   = in_valid_i & rdy_q;
  assign cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s     = accept_s & (cnt_inc_s == nv_q);
  assign launch_s   = start_i & ((state_q == IDLE) | (state_q == DONE));
  assign sig_step_s = misr_step(sig_q, in_data_i);

  // state register
  always_ff @(posedge clk_i or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = (num_vecs_i == {CNT_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output decode from the next state so the status flags are registered
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    rdy_d  = 1'b0;
    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
      end
      RUN: begin
        busy_d = 1'b1;
        done_d = 1'b0;
        rdy_d  = 1'b1;
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        rdy_d  = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
      end
    endcase
  end

  // datapath next values: launch, accumulate, verdict
  always_comb begin
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    nv_d     = nv_q;
    golden_d = golden_q;
    pass_d   = pass_q;
    if (launch_s) begin
      sig_d    = SEED;
      cnt_d    = {CNT_W{1'b0}};
      nv_d     = num_vecs_i;
      golden_d = golden_i;
      // An empty run finishes immediately with the seed as its signature.
      pass_d   = (num_vecs_i == {CNT_W{1'b0}}) ? (SEED == golden_i) : 1'b0;
    end else if (accept_s) begin
      sig_d = sig_step_s;
      cnt_d = cnt_inc_s;
      if (last_s) begin
        pass_d = (sig_step_s == golden_q);
      end else begin
        pass_d = pass_q;
      end
    end else begin
      sig_d = sig_q;
    end
  end

  // datapath and status registers
  always_ff @(posedge clk_i or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      sig_q    <= SEED;
      cnt_q    <= {CNT_W{1'b0}};
      nv_q     <= {CNT_W{1'b0}};
      golden_q <= {WIDTH{1'b0}};
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      nv_q     <= nv_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready_o = rdy_q;
  assign sig_o      = sig_q;
  assign vec_cnt_o  = cnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;

endmodule

// File: tb/tb_expr_result_misr.sv
module tb_expr_result_misr;

  localparam int WIDTH = 90;
  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [CNT_W-1:0] num_vecs_i;
  logic [WIDTH-1:0] golden_i;
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] sig_o;
  logic [CNT_W-1:0] vec_cnt_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;

  expr_result_misr dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .num_vecs_i (num_vecs_i),
    .golden_i   (golden_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .sig_o      (sig_o),
    .vec_cnt_o  (vec_cnt_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected verdict record: {sig, vec_cnt, pass}
  typedef logic [WIDTH+CNT_W:0] verdict_t;
  verdict_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: a verdict is presented when done rises, or stays high right
  // after a start (empty run launched from DONE).
  logic done_prev  = 1'b0;
  logic start_prev = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_i && done_o && (!done_prev || start_prev)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_verdict", 128'd1, 128'd0);
      end else begin
        verdict_t e;
        e = exp_q.pop_front();
        check("verdict_sig",  {38'd0, sig_o},     {38'd0, e[WIDTH+CNT_W:CNT_W+1]});
        check("verdict_cnt",  {112'd0, vec_cnt_o}, {112'd0, e[CNT_W:1]});
        check("verdict_pass", {127'd0, pass_o},    {127'd0, e[0]});
      end
    end
    done_prev  = done_o;
    start_prev = start_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] nv, input logic [WIDTH-1:0] g,
                           input logic [WIDTH-1:0] esig, input logic [CNT_W-1:0] ecnt,
                           input logic epass);
    exp_q.push_back({esig, ecnt, epass});
    start_i    = 1'b1;
    num_vecs_i = nv;
    golden_i   = g;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    tick();
    in_valid_i = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done_o && k < 20) begin
      tick();
      k++;
    end
    if (!done_o) check(name, 128'd0, 128'd1);
    tick();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_sig"},  {38'd0, sig_o}, 128'd0);
    check({name, "_cnt"},  {112'd0, vec_cnt_o}, 128'd0);
    check({name, "_flags"}, {124'd0, busy_o, done_o, pass_o, in_ready_o}, 128'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    num_vecs_i = '0;
    golden_i   = '0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_i = 1'b0;
    repeat (4) tick();

    // 1: single beat
    start_run(16'd1, 90'h1, 90'h1, 16'd1, 1'b1);
    check("t1_ready", {127'd0, in_ready_o}, 128'd1);
    check("t1_busy",  {127'd0, busy_o}, 128'd1);
    beat(90'h1);
    wait_done("t1_timeout");

    // 2: shift, then feedback through the taps
    start_run(16'd2, 90'h2, 90'h2, 16'd2, 1'b1);
    beat(90'h1);
    beat(90'h0);
    wait_done("t2a_timeout");
    start_run(16'd2, 90'h2D, 90'h2D, 16'd2, 1'b1);
    beat(90'h1 << 89);
    beat(90'h0);
    wait_done("t2b_timeout");

    // 3: gaps and an ignored start mid-run; 1,2,3 -> 1, 0, 3
    start_run(16'd3, 90'h3, 90'h3, 16'd3, 1'b1);
    tick();
    beat(90'h1);
    tick(); tick();
    start_i = 1'b1; num_vecs_i = 16'd1; golden_i = 90'h0;
    tick();
    start_i = 1'b0;
    check("t3_midrun_cnt", {112'd0, vec_cnt_o}, 128'd1);
    beat(90'h2);
    tick();
    beat(90'h3);
    wait_done("t3_timeout");

    // 4: empty runs, with in_valid held high
    in_valid_i = 1'b1; in_data_i = 90'h7;
    start_run(16'd0, 90'h0, 90'h0, 16'd0, 1'b1);
    check("t4a_done", {127'd0, done_o}, 128'd1);
    tick();
    start_run(16'd0, 90'h5, 90'h0, 16'd0, 1'b0);
    tick();
    check("t4b_sig_hold", {38'd0, sig_o}, 128'd0);
    in_valid_i = 1'b0; in_data_i = '0;

    // 5: 3,5,7,9 -> 3,3,1,B; golden off by one bit
    start_run(16'd4, 90'hA, 90'hB, 16'd4, 1'b0);
    beat(90'h3); beat(90'h5); beat(90'h7); beat(90'h9);
    check("t5_done_next", {127'd0, done_o}, 128'd1);
    in_valid_i = 1'b1; in_data_i = 90'h1234;
    repeat (3) tick();
    check("t5_ready_low", {127'd0, in_ready_o}, 128'd0);
    check("t5_sig_frozen", {38'd0, sig_o}, 128'hB);
    check("t5_cnt_frozen", {112'd0, vec_cnt_o}, 128'd4);
    in_valid_i = 1'b0; in_data_i = '0;

    // 6: asynchronous reset after 2 of 4 beats
    exp_q.push_back({90'hB, 16'd4, 1'b1});
    start_i = 1'b1; num_vecs_i = 16'd4; golden_i = 90'hB;
    tick();
    start_i = 1'b0;
    beat(90'h3); beat(90'h5);
    check("t6_mid_cnt", {112'd0, vec_cnt_o}, 128'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_vals("t6_async");
    // drop the verdict of the aborted run
    void'(exp_q.pop_back());
    tick();
    rst_i = 1'b0;
    repeat (4) tick();
    check_reset_vals("t6_after");
    start_run(16'd4, 90'hB, 90'hB, 16'd4, 1'b1);
    beat(90'h3); beat(90'h5); beat(90'h7); beat(90'h9);
    wait_done("t6_timeout");

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      check("verdicts_pending", exp_q.size(), 128'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
